// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter driving a shared 4:1 mux select, with a registered data output.
// Optional define MUXARB_LOCK_EN adds a lock input that lets the owner hold the grant past HOLD cycles.
module mux4_rr_arbiter #(
    parameter int unsigned W    = 8,
    parameter int unsigned HOLD = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [3:0]     req,
    input  logic [4*W-1:0] din,
`ifdef MUXARB_LOCK_EN
    input  logic           lock,
`endif
    output logic [3:0]     gnt,
    output logic [1:0]     sel,
    output logic           busy,
    output logic [W-1:0]   dout
);

    localparam int unsigned CW = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [CW-1:0] CntMax = CW'(HOLD - 1);

    typedef enum logic {StIdle, StGrant} state_t;

    state_t        r_state, w_state_d;
    logic [1:0]    r_ptr, w_ptr_d;
    logic [1:0]    r_sel, w_sel_d;
    logic [CW-1:0] r_cnt, w_cnt_d;
    logic [W-1:0]  r_dout, w_dout_d;

    logic [1:0]    w_scan_ptr;
    logic [1:0]    w_pick;
    logic          w_any;
    logic          w_lock_hold;
    logic          w_release;

    // On release the scan starts just past the outgoing owner, matching the ptr update.
    assign w_scan_ptr = (r_state == StGrant) ? (r_sel + 2'd1) : r_ptr;
    assign w_any      = |req;

    always_comb begin
        w_pick = w_scan_ptr;
        for (int i = 3; i >= 0; i--) begin
            if (req[w_scan_ptr + 2'(i)]) begin
                w_pick = w_scan_ptr + 2'(i);
            end
        end
    end

`ifdef MUXARB_LOCK_EN
    assign w_lock_hold = lock && req[r_sel];
`else
    assign w_lock_hold = 1'b0;
`endif

    assign w_release = !req[r_sel] || ((r_cnt == CntMax) && !w_lock_hold);

    always_comb begin
        w_state_d = r_state;
        w_ptr_d   = r_ptr;
        w_sel_d   = r_sel;
        w_cnt_d   = r_cnt;
        w_dout_d  = '0;
        unique case (r_state)
            StIdle: begin
                if (w_any) begin
                    w_state_d = StGrant;
                    w_sel_d   = w_pick;
                    w_cnt_d   = '0;
                end
            end
            StGrant: begin
                w_dout_d = din[r_sel*W +: W];
                if (w_release) begin
                    w_ptr_d = r_sel + 2'd1;
                    w_cnt_d = '0;
                    if (w_any) begin
                        w_sel_d = w_pick;
                    end else begin
                        w_state_d = StIdle;
                        w_sel_d   = 2'd0;
                    end
                end else if (!w_lock_hold) begin
                    w_cnt_d = r_cnt + CW'(1);
                end
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StIdle;
            r_ptr   <= 2'd0;
            r_sel   <= 2'd0;
            r_cnt   <= '0;
            r_dout  <= '0;
        end else begin
            r_state <= w_state_d;
            r_ptr   <= w_ptr_d;
            r_sel   <= w_sel_d;
            r_cnt   <= w_cnt_d;
            r_dout  <= w_dout_d;
        end
    end

    assign busy = (r_state == StGrant);
    assign sel  = r_sel;
    assign gnt  = busy ? (4'b0001 << r_sel) : 4'b0000;
    assign dout = r_dout;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Self-checking bench for mux4_rr_arbiter: directed scenarios plus randomized traffic
// compared against a cycle-level behavioural model of the arbitration rules.
module tb_mux4_rr_arbiter;

    localparam int W    = 8;
    localparam int HOLD = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic [3:0]     req;
    logic [4*W-1:0] din;
    logic           lock;
    logic [3:0]     gnt;
    logic [1:0]     sel;
    logic           busy;
    logic [W-1:0]   dout;

    int n_checks = 0;
    int n_errors = 0;

    // Model state: owner index or -1 when idle
    int m_owner;
    int m_cnt;
    int m_ptr;
    int m_dout;

    mux4_rr_arbiter #(.W(W), .HOLD(HOLD)) dut (
        .clk  (clk),
        .rst  (rst),
        .req  (req),
        .din  (din),
`ifdef MUXARB_LOCK_EN
        .lock (lock),
`endif
        .gnt  (gnt),
        .sel  (sel),
        .busy (busy),
        .dout (dout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int pick_from(input int start);
        for (int k = 0; k < 4; k++) begin
            if (req[(start + k) % 4]) return (start + k) % 4;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_cnt   = 0;
        m_ptr   = 0;
        m_dout  = 0;
    endtask

    task automatic model_step();
        int nd;
        nd = (m_owner >= 0) ? int'((din >> (m_owner * W)) & 32'hFF) : 0;
        if (m_owner < 0) begin
            m_owner = pick_from(m_ptr);
            m_cnt   = 0;
        end else if (!req[m_owner] || m_cnt == HOLD - 1) begin
            m_ptr   = (m_owner + 1) % 4;
            m_owner = pick_from(m_ptr);
            m_cnt   = 0;
        end else begin
            m_cnt++;
        end
        m_dout = nd;
    endtask

    task automatic compare_model();
        logic [3:0] e_gnt;
        e_gnt = (m_owner < 0) ? 4'b0000 : 4'(1 << m_owner);
        check("gnt",  32'(gnt),  32'(e_gnt));
        check("sel",  32'(sel),  (m_owner < 0) ? 32'd0 : 32'(m_owner));
        check("busy", 32'(busy), (m_owner < 0) ? 32'd0 : 32'd1);
        check("dout", 32'(dout), 32'(m_dout));
    endtask

    // One clock: model advances at the edge, DUT sampled on the falling edge.
    task automatic tick();
        @(posedge clk);
        if (rst) model_reset();
        else     model_step();
        @(negedge clk);
        compare_model();
    endtask

    task automatic do_reset(input logic [3:0] r);
        rst = 1'b1;
        req = r;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst  = 1'b1;
        req  = 4'b0000;
        din  = '0;
        lock = 1'b0;
        model_reset();
        @(negedge clk);

        // 1: requests under reset are ignored, then a sole requester holds continuously
        do_reset(4'b0001);
        check("t1_rst_gnt", 32'(gnt), 32'd0);
        tick();
        check("t1_first_gnt", 32'(gnt), 32'b0001);
        for (int i = 0; i < 9; i++) tick();
        check("t1_sole_regrant", 32'(gnt), 32'b0001);

        // 2: full contention rotates every HOLD cycles without gaps
        do_reset(4'b1111);
        for (int i = 1; i <= 20; i++) begin
            tick();
            check("t2_rotate_gnt", 32'(gnt), 32'(1 << (((i - 1) / HOLD) % 4)));
            check("t2_rotate_sel", 32'(sel), 32'(((i - 1) / HOLD) % 4));
        end

        // 3: owner drops early; next grant skips the idle source 1
        do_reset(4'b0101);
        tick();
        tick();
        req = 4'b0100;
        tick();
        check("t3_skip_gnt", 32'(gnt), 32'b0100);

        // 4: dout follows the selected source one clock after the grant
        din = '0;
        din[0*W +: W] = 8'hA5;
        din[2*W +: W] = 8'h3C;
        do_reset(4'b0101);
        tick();
        check("t4_gnt0", 32'(gnt), 32'b0001);
        tick();
        check("t4_dout_a5", 32'(dout), 32'hA5);
        for (int i = 0; i < 3; i++) tick();
        check("t4_gnt2", 32'(gnt), 32'b0100);
        tick();
        check("t4_dout_3c", 32'(dout), 32'h3C);

        // 5: asynchronous reset mid-grant clears outputs without a clock edge
        din = 32'h11223344;
        do_reset(4'b1111);
        for (int i = 0; i < 7; i++) tick();
        check("t5_pre_gnt", 32'(gnt), 32'b0010);
        #2;
        rst = 1'b1;
        #1;
        check("t5_async_gnt",  32'(gnt),  32'd0);
        check("t5_async_sel",  32'(sel),  32'd0);
        check("t5_async_busy", 32'(busy), 32'd0);
        check("t5_async_dout", 32'(dout), 32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        tick();
        check("t5_after_rst_gnt", 32'(gnt), 32'b0001);

        // Randomized traffic against the model, with sticky requests
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) req = 4'($urandom);
            din = $urandom;
            tick();
            check("rnd_onehot", 32'($countones(gnt) <= 1), 32'd1);
        end

        // Same again but with HOLD-timeout-heavy full contention
        req = 4'b1111;
        for (int i = 0; i < 40; i++) begin
            din = $urandom;
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
